// File: rtl/clarvi_sliced_decode_pkg.sv
// Shared RISC-V decode definitions for the sliced CLARVI pipeline: operation and
// register types, opcode constants, the decoded-field record and the slice ordering rule.
package clarvi_sliced_decode_pkg;

  typedef logic [4:0] register_t;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LOAD, OP_STORE, OP_FENCE, OP_SYSTEM, OP_INVALID
  } operation_t;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32    = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  typedef struct packed {
    operation_t op;
    register_t  rd;
    register_t  rs1;
    register_t  rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic       imm_used;
    logic       shift_imm;
    logic [5:0] shamt;
  } fields_t;

  // Compares and right shifts need the most significant slice first; word shifts
  // walk the low word downwards and then the high word downwards.
  function automatic int part_order(input operation_t op, input int cnt, input int num_parts);
    int h;
    h = num_parts / 2;
    case (op)
      OP_SLT, OP_SLTU, OP_BLT, OP_BLTU, OP_BGE, OP_BGEU, OP_SRL, OP_SRA:
        return num_parts - 1 - cnt;
      OP_SRLW, OP_SRAW:
        return (cnt < h) ? (h - 1 - cnt) : (3 * h - 1 - cnt);
      default:
        return cnt;
    endcase
  endfunction

endpackage

// File: rtl/clarvi_sliced_decode_fields.sv
// Whole-instruction decode: operation, register fields, usage flags and the
// full-width sign-extended immediate. Purely combinational.
module clarvi_instr_fields
  import clarvi_sliced_decode_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output fields_t         fields,
  output logic [XLEN-1:0] imm
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic       f7_ok;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign alt    = instr[30];
  assign f7_ok  = (instr[31:25] & 7'b1011111) == 7'b0;

  function automatic operation_t alu_op(input logic [2:0] f3, input logic a);
    operation_t r;
    case (f3)
      3'b000:  r = a ? OP_SUB : OP_ADD;
      3'b001:  r = OP_SLL;
      3'b010:  r = OP_SLT;
      3'b011:  r = OP_SLTU;
      3'b100:  r = OP_XOR;
      3'b101:  r = a ? OP_SRA : OP_SRL;
      3'b110:  r = OP_OR;
      default: r = OP_AND;
    endcase
    return r;
  endfunction

  function automatic operation_t word_op(input logic [2:0] f3, input logic a);
    operation_t r;
    case (f3)
      3'b000:  r = a ? OP_SUBW : OP_ADDW;
      3'b001:  r = OP_SLLW;
      3'b101:  r = a ? OP_SRAW : OP_SRLW;
      default: r = OP_INVALID;
    endcase
    return r;
  endfunction

  always_comb begin
    fields          = '0;
    fields.op       = OP_INVALID;
    fields.rd       = instr[11:7];
    fields.rs1      = instr[19:15];
    fields.rs2      = instr[24:20];
    fields.shamt    = {instr[25] & (opcode != OPC_OP_IMM32), instr[24:20]};
    case (opcode)
      OPC_LUI:   begin fields.op = OP_LUI;   fields.imm_used = 1'b1; end
      OPC_AUIPC: begin fields.op = OP_AUIPC; fields.imm_used = 1'b1; end
      OPC_JAL:   begin fields.op = OP_JAL;   fields.imm_used = 1'b1; end
      OPC_JALR: begin
        fields.op       = OP_JALR;
        fields.rs1_used = 1'b1;
        fields.imm_used = 1'b1;
      end
      OPC_BRANCH: begin
        fields.rs1_used = 1'b1;
        fields.rs2_used = 1'b1;
        fields.imm_used = 1'b1;
        case (funct3)
          3'b000:  fields.op = OP_BEQ;
          3'b001:  fields.op = OP_BNE;
          3'b100:  fields.op = OP_BLT;
          3'b101:  fields.op = OP_BGE;
          3'b110:  fields.op = OP_BLTU;
          3'b111:  fields.op = OP_BGEU;
          default: fields.op = OP_INVALID;
        endcase
      end
      OPC_LOAD: begin
        fields.op       = OP_LOAD;
        fields.rs1_used = 1'b1;
        fields.imm_used = 1'b1;
      end
      OPC_STORE: begin
        fields.op       = OP_STORE;
        fields.rs1_used = 1'b1;
        fields.rs2_used = 1'b1;
        fields.imm_used = 1'b1;
      end
      OPC_OP_IMM: begin
        fields.op        = alu_op(funct3, alt && funct3 == F3_SRL_SRA);
        fields.rs1_used  = 1'b1;
        fields.imm_used  = 1'b1;
        fields.shift_imm = (funct3 == F3_SLL) || (funct3 == F3_SRL_SRA);
      end
      OPC_OP_IMM32: begin
        fields.op        = word_op(funct3, alt && funct3 == F3_SRL_SRA);
        fields.rs1_used  = 1'b1;
        fields.imm_used  = 1'b1;
        fields.shift_imm = (funct3 == F3_SLL) || (funct3 == F3_SRL_SRA);
      end
      OPC_OP: begin
        fields.rs1_used = 1'b1;
        fields.rs2_used = 1'b1;
        if (f7_ok && !(alt && funct3 != F3_ADD_SUB && funct3 != F3_SRL_SRA))
          fields.op = alu_op(funct3, alt);
      end
      OPC_OP_32: begin
        fields.rs1_used = 1'b1;
        fields.rs2_used = 1'b1;
        if (f7_ok && !(alt && funct3 != F3_ADD_SUB && funct3 != F3_SRL_SRA))
          fields.op = word_op(funct3, alt);
      end
      OPC_MISC_MEM: fields.op = OP_FENCE;
      OPC_SYSTEM:   fields.op = OP_SYSTEM;
      default:      fields.op = OP_INVALID;
    endcase
  end

  always_comb begin
    case (opcode)
      OPC_LUI, OPC_AUIPC:
        imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      OPC_JAL:
        imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      OPC_BRANCH:
        imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_STORE:
        imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      default:
        imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
    endcase
  end

endmodule

// File: rtl/clarvi_sliced_decode.sv
// Sliced decode stage: steps one instruction through NUM_PARTS operand slices with
// forwarding and load-use stalls. Define CLARVI_FWD_EX_EN to allow forwarding from EX.
module clarvi_sliced_decode
  import clarvi_sliced_decode_pkg::*;
#(
  parameter int SLICE_W   = 16,
  parameter int XLEN      = 64,
  parameter int NUM_PARTS = XLEN / SLICE_W,
  parameter int PART_W    = $clog2(NUM_PARTS)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [31:0]                 in_instr,
  input  logic [XLEN-1:0]             in_pc,
  input  logic                        in_valid,
  input  logic                        stall_stage,
  input  logic [SLICE_W-1:0]          rs1_fetched,
  input  logic [SLICE_W-1:0]          rs2_fetched,
  input  logic [2:0]                  fwd_valid,
  input  logic [2:0]                  fwd_wb_en,
  input  logic [2:0][4:0]             fwd_rd,
  input  logic [2:0][PART_W-1:0]      fwd_part,
  input  logic [2:0][SLICE_W-1:0]     fwd_value,
  input  logic                        ex_is_load,
  input  logic                        mem_address_error,
  output operation_t                  dec_op,
  output register_t                   dec_rd,
  output register_t                   dec_rs1,
  output register_t                   dec_rs2,
  output logic [XLEN-1:0]             dec_pc,
  output logic [PART_W-1:0]           dec_part,
  output logic [SLICE_W-1:0]          dec_imm,
  output logic                        dec_imm_used,
  output logic                        dec_last_part,
  output logic [SLICE_W-1:0]          rs1_value,
  output logic [SLICE_W-1:0]          rs2_value,
  output logic                        stall_for_load_dep,
  output logic                        stall_for_decode
);

  localparam logic [PART_W-1:0] LAST_CNT = PART_W'(NUM_PARTS - 1);

  logic [PART_W-1:0]                 cnt;
  fields_t                           f;
  logic [XLEN-1:0]                   imm_full;
  logic [NUM_PARTS-1:0][SLICE_W-1:0] imm_slices;
  logic [2:0]                        eligible;
  logic [2:0]                        fwd_ok;
  logic                              ex_src_match;
  logic                              load_dep;

  clarvi_instr_fields #(.XLEN(XLEN)) u_fields (
    .instr  (in_instr),
    .fields (f),
    .imm    (imm_full)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if (!in_valid)
      cnt <= '0;
    else if (!(stall_stage || stall_for_load_dep))
      cnt <= cnt + PART_W'(1);
  end

  assign dec_op           = f.op;
  assign dec_rd           = f.rd;
  assign dec_rs1          = f.rs1;
  assign dec_rs2          = f.rs2;
  assign dec_pc           = in_pc;
  assign dec_part         = PART_W'(part_order(f.op, int'(cnt), NUM_PARTS));
  assign stall_for_decode = in_valid && (cnt != LAST_CNT);
  assign dec_last_part    = in_valid && (cnt == LAST_CNT);
  assign imm_slices       = imm_full;
  assign dec_imm          = f.shift_imm ? SLICE_W'(f.shamt) : imm_slices[dec_part];
  assign dec_imm_used     = f.imm_used;

  always_comb begin
    for (int s = 0; s < 3; s++)
      eligible[s] = fwd_valid[s] && fwd_wb_en[s] && (fwd_rd[s] != 5'd0) &&
                    (fwd_part[s] == dec_part);
    fwd_ok = eligible;
`ifdef CLARVI_FWD_EX_EN
    fwd_ok[0] = eligible[0] && !ex_is_load;
`else
    fwd_ok[0] = 1'b0;
`endif
  end

  // Walk from WB up to EX so the youngest matching producer wins.
  function automatic logic [SLICE_W-1:0] pick(
    input logic                    used,
    input register_t               rs,
    input logic [SLICE_W-1:0]      fetched,
    input logic [2:0]              ok,
    input logic [2:0][4:0]         rd,
    input logic [2:0][SLICE_W-1:0] val
  );
    logic [SLICE_W-1:0] r;
    r = fetched;
    if (used && rs != 5'd0)
      for (int s = 2; s >= 0; s--)
        if (ok[s] && rd[s] == rs)
          r = val[s];
    return r;
  endfunction

  assign rs1_value = pick(f.rs1_used, f.rs1, rs1_fetched, fwd_ok, fwd_rd, fwd_value);
  assign rs2_value = pick(f.rs2_used, f.rs2, rs2_fetched, fwd_ok, fwd_rd, fwd_value);

  assign ex_src_match = in_valid && ((f.rs1_used && f.rs1 == fwd_rd[0]) ||
                                     (f.rs2_used && f.rs2 == fwd_rd[0]));
  assign load_dep     = ex_src_match && (cnt == '0) && fwd_valid[0] &&
                        ex_is_load && !mem_address_error;

`ifdef CLARVI_FWD_EX_EN
  assign stall_for_load_dep = load_dep;
`else
  assign stall_for_load_dep = load_dep || (ex_src_match && eligible[0]);
`endif

endmodule
